pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core, sitting beside id_stage.
//  Detects load-use hazards and drives ld_risk back into id_stage.
//  Sequences the multi-cycle mul/div unit (start, wait, kill).
//  Generates IF/ID and ID/EX stall and flush controls for branch redirects and traps.
// PARAMETERS
//  RF_AW       5   register-file address width (matches `RF_ADDR_WIDTH)
//  MD_TIMEOUT  40  max MD_WAIT cycles before forced exit; must be >= unit latency + 2
//  TRAP_FLUSH  2   cycles both pipe registers are flushed after a trap or mret
// PORTS
//  clk            in   1     core clock, all state on rising edge
//  rst_n          in   1     synchronous reset, active low
//  id_valid       in   1     ID stage holds a valid instruction
//  id_rs1_used    in   1     ID instruction reads rs1
//  id_rs2_used    in   1     ID instruction reads rs2
//  id_rf_raddr1   in   RF_AW ID rs1 address
//  id_rf_raddr2   in   RF_AW ID rs2 address
//  id_is_md_inst  in   1     ID holds a mul or div instruction (already qualified by id_valid)
//  ex_is_load     in   1     EX stage holds a load
//  ex_rd_addr     in   RF_AW EX destination register
//  md_done        in   1     mul/div unit result valid (single-cycle pulse)
//  bj_redirect    in   1     EX resolved taken branch/jump or mispredict
//  trap_take      in   1     MEM commits exception or interrupt (one-cycle pulse)
//  mret_take      in   1     MEM commits mret (one-cycle pulse)
//  ld_risk        out  1     load-use hazard this cycle; also suppresses EX forwarding
//  stall_if       out  1     hold PC and IF/ID register
//  stall_id       out  1     hold ID/EX register contents
//  flush_if2id    out  1     insert bubble into IF/ID
//  flush_id2ex    out  1     insert bubble into ID/EX
//  md_start       out  1     one-cycle start pulse to mul/div unit
//  md_kill        out  1     one-cycle abort pulse to mul/div unit
//  md_timeout     out  1     sticky error flag, cleared only by reset
//  state_o        out  2     FSM state: 0 RUN, 1 MD_WAIT, 2 TRAP
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state RUN, counters 0, md_timeout 0.
//  During reset every output is 0 except state_o=0.
//  ld_risk (combinational):
//   ex_is_load & id_valid & ex_rd_addr!=0 &
//   ((id_rs1_used & raddr1==ex_rd_addr) | (id_rs2_used & raddr2==ex_rd_addr)).
//   ld_risk is gated to 0 outside RUN.
//  RUN:
//   - trap_take|mret_take: flush_if2id=flush_id2ex=1; cnt<=TRAP_FLUSH-1; go TRAP.
//   - else bj_redirect: flush_if2id=flush_id2ex=1 this cycle only; no stall; stay RUN.
//   - else id_is_md_inst: md_start=1; stall_if=stall_id=1; cnt<=0; go MD_WAIT.
//   - else ld_risk: stall_if=1, flush_id2ex=1 (one bubble), stall_id=0.
//   - Priority: trap/mret > redirect > md issue > ld_risk.
//  MD_WAIT:
//   - stall_if=stall_id=1 every cycle; cnt increments by 1.
//   - md_done: drop stalls in that same cycle; go RUN. md_start pulses only once per instruction.
//   - trap_take|mret_take: md_kill=1; flushes as in RUN; go TRAP. Takes priority over md_done.
//   - bj_redirect is ignored in MD_WAIT, because EX is frozen.
//   - cnt==MD_TIMEOUT-1 without md_done: md_kill=1, md_timeout<=1, stalls drop; go RUN.
//  TRAP:
//   - flush_if2id=flush_id2ex=1; no stall; cnt decrements; go RUN when cnt==0.
//   - A new trap_take in TRAP reloads cnt to TRAP_FLUSH-1.
//  Latency: md_start appears in the same cycle the md instruction is in ID.
//   Stall release is combinational on md_done.
//  Mid-operation reset: any state goes to RUN at the next edge.
//   No md_kill is issued, because reset clears the unit too.
//  Counter is 6 bits and saturates; it is never compared outside the current state.
// TESTING
//  1 lw x5 in EX, ID add x6,x5,x1 (rs1_used)
//    -> ld_risk=1, stall_if=1, flush_id2ex=1 for exactly 1 cycle.
//    Same with ex_rd_addr=0 -> ld_risk=0.
//  2 id_is_md_inst in RUN, md_done 34 cycles later
//    -> md_start for 1 cycle; stall_if/stall_id high 34 cycles; state_o 1 then 0.
//  3 MD_WAIT, trap_take on cycle 10
//    -> md_kill=1; both flushes for 2 cycles; state 1->2->2->0; no md_start repeat.
//  4 MD_WAIT, md_done never asserted, MD_TIMEOUT=40
//    -> md_kill and md_timeout=1 at cycle 40; md_timeout stays set until rst_n=0.
//  5 bj_redirect and ld_risk in the same RUN cycle
//    -> flushes only, stall_if=0. Then trap_take together with bj_redirect -> TRAP entered.
//  6 rst_n=0 during MD_WAIT
//    -> next edge: state RUN, all outputs 0, md_kill stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer beside id_stage: load-use hazard, mul/div start/wait/kill, redirect and trap flushes.
// Latency: all control outputs are combinational on the current state and inputs; state/counter update on the next edge.
// Backpressure: freezes IF (and ID/EX during mul/div) via stall outputs; stalls drop in the same cycle md_done arrives.
module pipe_hazard_ctrl #(
  parameter int RF_AW      = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int TRAP_FLUSH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RF_AW-1:0] id_rf_raddr1,
  input  logic [RF_AW-1:0] id_rf_raddr2,
  input  logic             id_is_md_inst,
  input  logic             ex_is_load,
  input  logic [RF_AW-1:0] ex_rd_addr,
  input  logic             md_done,
  input  logic             bj_redirect,
  input  logic             trap_take,
  input  logic             mret_take,
  output logic             ld_risk,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_if2id,
  output logic             flush_id2ex,
  output logic             md_start,
  output logic             md_kill,
  output logic             md_timeout,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_TRAP    = 2'd2
  } state_e;

  // Counter reload values; the counter is 6 bits wide and saturates.
  localparam logic [5:0] TRAP_CNT = 6'(TRAP_FLUSH - 1);
  localparam logic [5:0] MD_LAST  = 6'(MD_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       md_timeout_q, md_timeout_d;

  logic hazard;
  logic ld_risk_c, stall_if_c, stall_id_c, flush_if2id_c, flush_id2ex_c;
  logic md_start_c, md_kill_c;
  logic trap_any;

  // Load-use hazard: ID reads a register that the load now in EX has not yet produced.
  always_comb begin
    hazard = ex_is_load & id_valid & (ex_rd_addr != '0) &
             ((id_rs1_used & (id_rf_raddr1 == ex_rd_addr)) |
              (id_rs2_used & (id_rf_raddr2 == ex_rd_addr)));
  end

  assign trap_any = trap_take | mret_take;

  // Next-state and control decode; priority is trap/mret > redirect > md issue > load-use.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    md_timeout_d  = md_timeout_q;
    ld_risk_c     = 1'b0;
    stall_if_c    = 1'b0;
    stall_id_c    = 1'b0;
    flush_if2id_c = 1'b0;
    flush_id2ex_c = 1'b0;
    md_start_c    = 1'b0;
    md_kill_c     = 1'b0;
    case (state_q)
      ST_RUN: begin
        ld_risk_c = hazard;
        if (trap_any) begin
          flush_if2id_c = 1'b1;
          flush_id2ex_c = 1'b1;
          cnt_d         = TRAP_CNT;
          state_d       = ST_TRAP;
        end else if (bj_redirect) begin
          flush_if2id_c = 1'b1;
          flush_id2ex_c = 1'b1;
        end else if (id_is_md_inst) begin
          md_start_c = 1'b1;
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          cnt_d      = '0;
          state_d    = ST_MD_WAIT;
        end else if (hazard) begin
          // One bubble into EX while the load completes.
          stall_if_c    = 1'b1;
          flush_id2ex_c = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        // Redirects are ignored here: EX is frozen behind the mul/div.
        if (trap_any) begin
          md_kill_c     = 1'b1;
          flush_if2id_c = 1'b1;
          flush_id2ex_c = 1'b1;
          cnt_d         = TRAP_CNT;
          state_d       = ST_TRAP;
        end else if (md_done) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (cnt_q == MD_LAST) begin
          md_kill_c    = 1'b1;
          md_timeout_d = 1'b1;
          cnt_d        = '0;
          state_d      = ST_RUN;
        end else begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          cnt_d      = (cnt_q == 6'h3f) ? cnt_q : cnt_q + 6'd1;
        end
      end
      ST_TRAP: begin
        flush_if2id_c = 1'b1;
        flush_id2ex_c = 1'b1;
        if (trap_take) begin
          cnt_d = TRAP_CNT;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and sticky timeout flag; reset wins over everything, no kill on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  // Outputs are forced low while reset is held so nothing escapes before the first edge.
  assign ld_risk     = rst_n & ld_risk_c;
  assign stall_if    = rst_n & stall_if_c;
  assign stall_id    = rst_n & stall_id_c;
  assign flush_if2id = rst_n & flush_if2id_c;
  assign flush_id2ex = rst_n & flush_id2ex_c;
  assign md_start    = rst_n & md_start_c;
  assign md_kill     = rst_n & md_kill_c;
  assign md_timeout  = rst_n & md_timeout_q;
  assign state_o     = rst_n ? state_q : 2'd0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
// Inputs change just after the falling edge; outputs are checked 1ns later.
// Output vector order: ld_risk stall_if stall_id flush_if2id flush_id2ex md_start md_kill md_timeout.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used;
  logic [4:0] id_rf_raddr1, id_rf_raddr2, ex_rd_addr;
  logic       id_is_md_inst, ex_is_load, md_done, bj_redirect, trap_take, mret_take;
  logic       ld_risk, stall_if, stall_id, flush_if2id, flush_id2ex;
  logic       md_start, md_kill, md_timeout;
  logic [1:0] state_o;
  logic [7:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RF_AW(5), .MD_TIMEOUT(40), .TRAP_FLUSH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rf_raddr1(id_rf_raddr1), .id_rf_raddr2(id_rf_raddr2),
    .id_is_md_inst(id_is_md_inst), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .md_done(md_done), .bj_redirect(bj_redirect), .trap_take(trap_take), .mret_take(mret_take),
    .ld_risk(ld_risk), .stall_if(stall_if), .stall_id(stall_id),
    .flush_if2id(flush_if2id), .flush_id2ex(flush_id2ex),
    .md_start(md_start), .md_kill(md_kill), .md_timeout(md_timeout), .state_o(state_o)
  );

  assign outs = {ld_risk, stall_if, stall_id, flush_if2id, flush_id2ex, md_start, md_kill, md_timeout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] exp_outs, input logic [1:0] exp_state);
    check({tag, ".outs"}, {24'd0, outs}, {24'd0, exp_outs});
    check({tag, ".state"}, {30'd0, state_o}, {30'd0, exp_state});
  endtask

  // Advance to the next falling edge; callers then set inputs and wait #1 before checking.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rf_raddr1 = 0; id_rf_raddr2 = 0; ex_rd_addr = 0;
    id_is_md_inst = 0; ex_is_load = 0; md_done = 0;
    bj_redirect = 0; trap_take = 0; mret_take = 0;
  endtask

  // lw x5 in EX, ID add x6,x5,x1
  task automatic set_ld_hazard();
    ex_is_load = 1; ex_rd_addr = 5'd5;
    id_valid = 1; id_rs1_used = 1; id_rs2_used = 1;
    id_rf_raddr1 = 5'd5; id_rf_raddr2 = 5'd1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    // Reset with aggressive inputs: everything must stay low.
    id_is_md_inst = 1; trap_take = 1; set_ld_hazard();
    next_cyc(); #1;
    check_all("rst", 8'b0000_0000, 2'd0);
    next_cyc(); rst_n = 1; idle_inputs(); #1;
    check_all("idle", 8'b0000_0000, 2'd0);

    // Load-use via rs1: one bubble, IF held.
    next_cyc(); set_ld_hazard(); #1;
    check_all("ld_rs1", 8'b1100_1000, 2'd0);
    next_cyc(); idle_inputs(); id_valid = 1; id_rs1_used = 1; id_rf_raddr1 = 5'd5; #1;
    check_all("ld_after", 8'b0000_0000, 2'd0);
    // Load-use via rs2 only.
    next_cyc(); idle_inputs(); ex_is_load = 1; ex_rd_addr = 5'd7; id_valid = 1;
    id_rs1_used = 1; id_rf_raddr1 = 5'd3; id_rs2_used = 1; id_rf_raddr2 = 5'd7; #1;
    check_all("ld_rs2", 8'b1100_1000, 2'd0);
    // Same register but rs2 not used.
    id_rs2_used = 0; #1;
    check_all("ld_rs2_unused", 8'b0000_0000, 2'd0);
    // x0 destination never hazards.
    next_cyc(); set_ld_hazard(); ex_rd_addr = 5'd0; id_rf_raddr1 = 5'd0; #1;
    check_all("ld_x0", 8'b0000_0000, 2'd0);
    // Invalid ID slot.
    next_cyc(); set_ld_hazard(); id_valid = 0; #1;
    check_all("ld_novalid", 8'b0000_0000, 2'd0);

    // Redirect with load-use in the same cycle: flush only, no stall.
    next_cyc(); set_ld_hazard(); bj_redirect = 1; #1;
    check_all("bj_ld", 8'b1001_1000, 2'd0);
    // Trap together with redirect enters TRAP.
    next_cyc(); idle_inputs(); bj_redirect = 1; trap_take = 1; #1;
    check_all("trap_bj", 8'b0001_1000, 2'd0);
    // In TRAP: hazard and md issue are masked.
    next_cyc(); idle_inputs(); set_ld_hazard(); id_is_md_inst = 1; #1;
    check_all("trap_c1", 8'b0001_1000, 2'd2);
    next_cyc(); #1;
    check_all("trap_c2", 8'b0001_1000, 2'd2);
    next_cyc(); idle_inputs(); #1;
    check_all("trap_exit", 8'b0000_0000, 2'd0);

    // mret entry, then a second trap inside TRAP reloads the counter.
    next_cyc(); mret_take = 1; #1;
    check_all("mret", 8'b0001_1000, 2'd0);
    next_cyc(); idle_inputs(); trap_take = 1; #1;
    check_all("reload_c1", 8'b0001_1000, 2'd2);
    next_cyc(); idle_inputs(); #1;
    check_all("reload_c2", 8'b0001_1000, 2'd2);
    next_cyc(); #1;
    check_all("reload_c3", 8'b0001_1000, 2'd2);
    next_cyc(); #1;
    check_all("reload_exit", 8'b0000_0000, 2'd0);

    // Mul/div with md_done 34 cycles after issue; instruction stays in ID while stalled.
    next_cyc(); id_is_md_inst = 1; #1;
    check_all("md_issue", 8'b0110_0100, 2'd0);
    for (int i = 1; i < 34; i++) begin
      next_cyc(); bj_redirect = (i == 5); #1;
      check_all($sformatf("md_wait%0d", i), 8'b0110_0000, 2'd1);
    end
    next_cyc(); bj_redirect = 0; md_done = 1; #1;
    check_all("md_done", 8'b0000_0000, 2'd1);
    next_cyc(); idle_inputs(); #1;
    check_all("md_back", 8'b0000_0000, 2'd0);

    // Trap on cycle 10 of MD_WAIT: kill, flushes, no second start.
    next_cyc(); id_is_md_inst = 1; #1;
    check_all("mdk_issue", 8'b0110_0100, 2'd0);
    for (int i = 1; i < 10; i++) begin
      next_cyc(); #1;
    end
    check_all("mdk_wait9", 8'b0110_0000, 2'd1);
    next_cyc(); trap_take = 1; md_done = 1; #1;
    check_all("mdk_kill", 8'b0001_1010, 2'd1);
    next_cyc(); trap_take = 0; md_done = 0; #1;
    check_all("mdk_t1", 8'b0001_1000, 2'd2);
    next_cyc(); #1;
    check_all("mdk_t2", 8'b0001_1000, 2'd2);
    next_cyc(); idle_inputs(); #1;
    check_all("mdk_run", 8'b0000_0000, 2'd0);

    // Timeout: no md_done, kill and sticky flag at cycle 40.
    next_cyc(); id_is_md_inst = 1; #1;
    check_all("to_issue", 8'b0110_0100, 2'd0);
    for (int i = 1; i < 40; i++) begin
      next_cyc(); #1;
    end
    check_all("to_wait39", 8'b0110_0000, 2'd1);
    next_cyc(); #1;
    check_all("to_kill", 8'b0000_0010, 2'd1);
    next_cyc(); idle_inputs(); #1;
    check_all("to_sticky", 8'b0000_0001, 2'd0);
    for (int i = 0; i < 5; i++) begin
      next_cyc(); #1;
    end
    check_all("to_sticky_hold", 8'b0000_0001, 2'd0);

    // Reset during MD_WAIT: back to RUN, no kill, sticky flag cleared.
    next_cyc(); id_is_md_inst = 1; #1;
    check_all("rw_issue", 8'b0110_0101, 2'd0);
    next_cyc(); next_cyc(); #1;
    check_all("rw_wait", 8'b0110_0001, 2'd1);
    next_cyc(); rst_n = 0; #1;
    check_all("rw_rst_on", 8'b0000_0000, 2'd0);
    next_cyc(); #1;
    check_all("rw_rst_edge", 8'b0000_0000, 2'd0);
    next_cyc(); rst_n = 1; idle_inputs(); #1;
    check_all("rw_release", 8'b0000_0000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
